// File: rtl/infifo_pkg.sv
// Shared definitions for the infifo thread scheduler and arbiter:
// thread-count defaults and the scheduler FSM state encoding.
package infifo_pkg;

  localparam int NUM_THREADS = 4;
  localparam int THREAD_BITS = 2;
  localparam int CNT_BITS    = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER    = 2'd1,
    HANDOFF = 2'd2
  } state_t;

endpackage

// File: rtl/rr_free_pick.sv
// Round-robin search of a free mask: returns the first set index after
// start, wrapping modulo NUM_THREADS; returns start when nothing is free.
module rr_free_pick #(
  parameter int NUM_THREADS = infifo_pkg::NUM_THREADS,
  parameter int THREAD_BITS = infifo_pkg::THREAD_BITS
) (
  input  logic [NUM_THREADS-1:0] free,
  input  logic [THREAD_BITS-1:0] start,
  output logic [THREAD_BITS-1:0] idx,
  output logic                   valid
);

  logic [THREAD_BITS-1:0] cand;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    idx   = start;
    valid = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_THREADS; k++) begin
      cand = THREAD_BITS'((int'(start) + k) % NUM_THREADS);
      if (!valid && free[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/infifo_thread_scheduler.sv
// Chooses the thread FIFO for the next packet from the shared small FIFO,
// gates small-FIFO reads for the packet and pulses enable_cpu after its last word.
module infifo_thread_scheduler
  import infifo_pkg::*;
#(
  parameter int NUM_THREADS = infifo_pkg::NUM_THREADS,
  parameter int THREAD_BITS = infifo_pkg::THREAD_BITS,
  parameter int CNT_BITS    = infifo_pkg::CNT_BITS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pkt_avail,
  input  logic                   word_valid,
  input  logic                   firstword_in,
  input  logic                   lastword_in,
  input  logic [NUM_THREADS-1:0] fifo_busy,
  output logic [THREAD_BITS-1:0] thread_sel,
  output logic [THREAD_BITS-1:0] thread_sel_next,
  output logic                   sched_valid,
  output logic                   smallfifo_rd_en,
  output logic                   enable_cpu,
  output logic [CNT_BITS-1:0]    pkt_count,
  output logic                   proto_err
);

  state_t                 state;
  logic [THREAD_BITS-1:0] last_grant;
  logic [THREAD_BITS-1:0] pick;
  logic                   pick_valid;
  logic [NUM_THREADS-1:0] reserved;
  logic [NUM_THREADS-1:0] free;
  logic                   first_seen;

  // A handed-off thread stays reserved until the arbiter reports it busy.
  assign free = ~fifo_busy & ~reserved;

  rr_free_pick #(
    .NUM_THREADS(NUM_THREADS),
    .THREAD_BITS(THREAD_BITS)
  ) u_pick (
    .free (free),
    .start(last_grant),
    .idx  (pick),
    .valid(pick_valid)
  );

  assign thread_sel_next = pick;
  assign sched_valid     = pick_valid;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      thread_sel      <= '0;
      last_grant      <= THREAD_BITS'(NUM_THREADS - 1);
      smallfifo_rd_en <= 1'b0;
      enable_cpu      <= 1'b0;
      pkt_count       <= '0;
      proto_err       <= 1'b0;
      reserved        <= '0;
      first_seen      <= 1'b0;
    end else begin
      reserved <= reserved & ~fifo_busy;
      case (state)
        IDLE: begin
          if (word_valid) proto_err <= 1'b1;
          if (pkt_avail && pick_valid) begin
            thread_sel      <= pick;
            last_grant      <= pick;
            first_seen      <= 1'b0;
            smallfifo_rd_en <= 1'b1;
            state           <= XFER;
          end
        end
        XFER: begin
          if (word_valid) begin
            first_seen <= 1'b1;
            // The first word must carry firstword_in and no later word may.
            if (first_seen == firstword_in) proto_err <= 1'b1;
            if (lastword_in) begin
              smallfifo_rd_en <= 1'b0;
              enable_cpu      <= 1'b1;
              state           <= HANDOFF;
            end
          end
        end
        HANDOFF: begin
          if (word_valid) proto_err <= 1'b1;
          enable_cpu           <= 1'b0;
          // Issued after the busy-clear above, so setting wins over a same-cycle busy.
          reserved[thread_sel] <= 1'b1;
          pkt_count            <= pkt_count + CNT_BITS'(1);
          state                <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_infifo_thread_scheduler.sv
// Directed scenarios plus a randomized run against a packet-level model of
// round-robin thread selection, framing and dispatch counting.
module tb_infifo_thread_scheduler;

  localparam int NT = 4;
  localparam int TB = 2;
  localparam int CB = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          pkt_avail;
  logic          word_valid;
  logic          firstword_in;
  logic          lastword_in;
  logic [NT-1:0] fifo_busy;
  logic [TB-1:0] thread_sel;
  logic [TB-1:0] thread_sel_next;
  logic          sched_valid;
  logic          smallfifo_rd_en;
  logic          enable_cpu;
  logic [CB-1:0] pkt_count;
  logic          proto_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  infifo_thread_scheduler dut (
    .clk            (clk),
    .reset          (reset),
    .pkt_avail      (pkt_avail),
    .word_valid     (word_valid),
    .firstword_in   (firstword_in),
    .lastword_in    (lastword_in),
    .fifo_busy      (fifo_busy),
    .thread_sel     (thread_sel),
    .thread_sel_next(thread_sel_next),
    .sched_valid    (sched_valid),
    .smallfifo_rd_en(smallfifo_rd_en),
    .enable_cpu     (enable_cpu),
    .pkt_count      (pkt_count),
    .proto_err      (proto_err)
  );

  // Round-robin reference: first free thread after last, else last.
  function automatic int rr_model(input int last, input logic [NT-1:0] free);
    for (int k = 1; k <= NT; k++) begin
      if (free[(last + k) % NT]) return (last + k) % NT;
    end
    return last;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pkt_avail    = 1'b0;
    word_valid   = 1'b0;
    firstword_in = 1'b0;
    lastword_in  = 1'b0;
  endtask

  task automatic word(input logic f, input logic l);
    word_valid   = 1'b1;
    firstword_in = f;
    lastword_in  = l;
  endtask

  task automatic do_reset();
    idle_inputs();
    fifo_busy = '0;
    reset     = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    fifo_busy = '0;
    reset     = 1'b1;
    step();
    step();
    checks++; if (smallfifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b exp 0", smallfifo_rd_en); end
    checks++; if (enable_cpu !== 1'b0) begin errors++; $display("FAIL reset_enable_cpu got %b exp 0", enable_cpu); end
    checks++; if (pkt_count !== 16'd0) begin errors++; $display("FAIL reset_pkt_count got %0d exp 0", pkt_count); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err got %b exp 0", proto_err); end
    checks++; if (thread_sel !== 2'd0) begin errors++; $display("FAIL reset_thread_sel got %0d exp 0", thread_sel); end
    checks++; if (thread_sel_next !== 2'd0) begin errors++; $display("FAIL reset_thread_sel_next got %0d exp 0", thread_sel_next); end
    checks++; if (sched_valid !== 1'b1) begin errors++; $display("FAIL reset_sched_valid got %b exp 1", sched_valid); end
    reset = 1'b0;
  endtask

  task automatic test_single_packet();
    do_reset();
    pkt_avail = 1'b1;
    step();
    pkt_avail = 1'b0;
    for (int w = 0; w < 4; w++) begin
      checks++; if (smallfifo_rd_en !== 1'b1) begin errors++; $display("FAIL pkt4_rd_en word %0d got %b exp 1", w, smallfifo_rd_en); end
      checks++; if (thread_sel !== 2'd0) begin errors++; $display("FAIL pkt4_thread_sel got %0d exp 0", thread_sel); end
      word(w == 0, w == 3);
      step();
    end
    idle_inputs();
    checks++; if (enable_cpu !== 1'b1) begin errors++; $display("FAIL pkt4_enable_cpu got %b exp 1", enable_cpu); end
    checks++; if (smallfifo_rd_en !== 1'b0) begin errors++; $display("FAIL pkt4_rd_en_handoff got %b exp 0", smallfifo_rd_en); end
    step();
    checks++; if (enable_cpu !== 1'b0) begin errors++; $display("FAIL pkt4_enable_pulse got %b exp 0", enable_cpu); end
    checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL pkt4_pkt_count got %0d exp 1", pkt_count); end
    checks++; if (thread_sel_next !== 2'd1) begin errors++; $display("FAIL pkt4_thread_sel_next got %0d exp 1", thread_sel_next); end
  endtask

  task automatic test_back_to_back();
    int            grants[$];
    int            en_cyc[$];
    logic [NT-1:0] echo_next;
    do_reset();
    echo_next = '0;
    pkt_avail = 1'b1;
    for (int c = 0; c < 40 && grants.size() < 4; c++) begin
      step();
      fifo_busy = fifo_busy | echo_next;
      echo_next = '0;
      if (enable_cpu === 1'b1) begin
        grants.push_back(int'(thread_sel));
        en_cyc.push_back(c);
        echo_next[thread_sel] = 1'b1;
      end
      if (smallfifo_rd_en === 1'b1) word(1'b1, 1'b1);
      else begin
        word_valid = 1'b0; firstword_in = 1'b0; lastword_in = 1'b0;
      end
    end
    checks++; if (grants.size() != 4) begin errors++; $display("FAIL b2b_grant_count got %0d exp 4", grants.size()); end
    for (int i = 0; i < grants.size(); i++) begin
      checks++; if (grants[i] != i) begin errors++; $display("FAIL b2b_grant_%0d got %0d exp %0d", i, grants[i], i); end
      if (i > 0) begin
        checks++; if (en_cyc[i] - en_cyc[i-1] != 3) begin errors++; $display("FAIL b2b_spacing_%0d got %0d exp 3", i, en_cyc[i] - en_cyc[i-1]); end
      end
    end
    idle_inputs();
    step();
    checks++; if (sched_valid !== 1'b0) begin errors++; $display("FAIL b2b_all_taken_sched_valid got %b exp 0", sched_valid); end
  endtask

  task automatic test_all_busy();
    do_reset();
    fifo_busy = 4'b1111;
    pkt_avail = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++; if (sched_valid !== 1'b0) begin errors++; $display("FAIL busy_sched_valid cyc %0d got %b exp 0", c, sched_valid); end
      checks++; if (smallfifo_rd_en !== 1'b0) begin errors++; $display("FAIL busy_rd_en cyc %0d got %b exp 0", c, smallfifo_rd_en); end
      step();
    end
    checks++; if (thread_sel_next !== 2'd3) begin errors++; $display("FAIL busy_thread_sel_next got %0d exp 3", thread_sel_next); end
    fifo_busy = 4'b1011;
    #1;
    checks++; if (sched_valid !== 1'b1) begin errors++; $display("FAIL release_sched_valid got %b exp 1", sched_valid); end
    checks++; if (thread_sel_next !== 2'd2) begin errors++; $display("FAIL release_thread_sel_next got %0d exp 2", thread_sel_next); end
    step();
    checks++; if (smallfifo_rd_en !== 1'b1) begin errors++; $display("FAIL release_rd_en got %b exp 1", smallfifo_rd_en); end
    checks++; if (thread_sel !== 2'd2) begin errors++; $display("FAIL release_thread_sel got %0d exp 2", thread_sel); end
    word(1'b1, 1'b1);
    pkt_avail = 1'b0;
    step();
    idle_inputs();
    checks++; if (enable_cpu !== 1'b1) begin errors++; $display("FAIL release_enable_cpu got %b exp 1", enable_cpu); end
    step();
  endtask

  task automatic test_skip_busy();
    do_reset();
    fifo_busy = 4'b0010;
    pkt_avail = 1'b1;
    step();
    checks++; if (thread_sel !== 2'd0) begin errors++; $display("FAIL skip_first_grant got %0d exp 0", thread_sel); end
    word(1'b1, 1'b1);
    step();
    word_valid = 1'b0; firstword_in = 1'b0; lastword_in = 1'b0;
    checks++; if (enable_cpu !== 1'b1) begin errors++; $display("FAIL skip_enable_cpu got %b exp 1", enable_cpu); end
    step();
    checks++; if (sched_valid !== 1'b1) begin errors++; $display("FAIL skip_sched_valid got %b exp 1", sched_valid); end
    checks++; if (thread_sel_next !== 2'd2) begin errors++; $display("FAIL skip_thread_sel_next got %0d exp 2", thread_sel_next); end
    step();
    checks++; if (smallfifo_rd_en !== 1'b1) begin errors++; $display("FAIL skip_rd_en got %b exp 1", smallfifo_rd_en); end
    checks++; if (thread_sel !== 2'd2) begin errors++; $display("FAIL skip_second_grant got %0d exp 2", thread_sel); end
    word(1'b1, 1'b1);
    pkt_avail = 1'b0;
    step();
    idle_inputs();
    pkt_avail = 1'b1;
    fifo_busy = 4'b1010;
    step();
    // Threads 0 and 2 handed off, arbiter has not flagged them busy yet.
    for (int c = 0; c < 3; c++) begin
      checks++; if (sched_valid !== 1'b0) begin errors++; $display("FAIL lag_sched_valid cyc %0d got %b exp 0", c, sched_valid); end
      checks++; if (smallfifo_rd_en !== 1'b0) begin errors++; $display("FAIL lag_rd_en cyc %0d got %b exp 0", c, smallfifo_rd_en); end
      step();
    end
    fifo_busy = 4'b1011;
    #1;
    checks++; if (sched_valid !== 1'b0) begin errors++; $display("FAIL lag_busy0_sched_valid got %b exp 0", sched_valid); end
    step();
    fifo_busy = 4'b1010;
    #1;
    checks++; if (sched_valid !== 1'b1) begin errors++; $display("FAIL unreserve_sched_valid got %b exp 1", sched_valid); end
    checks++; if (thread_sel_next !== 2'd0) begin errors++; $display("FAIL unreserve_thread_sel_next got %0d exp 0", thread_sel_next); end
    step();
    checks++; if (thread_sel !== 2'd0) begin errors++; $display("FAIL unreserve_grant got %0d exp 0", thread_sel); end
    word(1'b1, 1'b1);
    pkt_avail = 1'b0;
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_proto_err();
    do_reset();
    pkt_avail = 1'b1;
    step();
    word(1'b1, 1'b0);
    pkt_avail = 1'b0;
    step();
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL proto_clean got %b exp 0", proto_err); end
    word(1'b1, 1'b0);
    step();
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_dup_first got %b exp 1", proto_err); end
    checks++; if (smallfifo_rd_en !== 1'b1) begin errors++; $display("FAIL proto_stay_xfer got %b exp 1", smallfifo_rd_en); end
    word(1'b0, 1'b1);
    step();
    idle_inputs();
    checks++; if (enable_cpu !== 1'b1) begin errors++; $display("FAIL proto_handoff got %b exp 1", enable_cpu); end
    step();
    step();
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_sticky got %b exp 1", proto_err); end

    do_reset();
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL proto_reset_clear got %b exp 0", proto_err); end
    word(1'b0, 1'b0);
    step();
    idle_inputs();
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_stray_word got %b exp 1", proto_err); end
    for (int c = 0; c < 3; c++) step();
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_stray_sticky got %b exp 1", proto_err); end

    do_reset();
    pkt_avail = 1'b1;
    step();
    word(1'b0, 1'b1);
    pkt_avail = 1'b0;
    step();
    idle_inputs();
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_missing_first got %b exp 1", proto_err); end
    checks++; if (enable_cpu !== 1'b1) begin errors++; $display("FAIL proto_missing_first_handoff got %b exp 1", enable_cpu); end
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    pkt_avail = 1'b1;
    step();
    pkt_avail = 1'b0;
    word(1'b1, 1'b0);
    step();
    word(1'b0, 1'b0);
    step();
    word(1'b0, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle_inputs();
    checks++; if (smallfifo_rd_en !== 1'b0) begin errors++; $display("FAIL midrst_rd_en got %b exp 0", smallfifo_rd_en); end
    checks++; if (pkt_count !== 16'd0) begin errors++; $display("FAIL midrst_pkt_count got %0d exp 0", pkt_count); end
    for (int c = 0; c < 4; c++) begin
      checks++; if (enable_cpu !== 1'b0) begin errors++; $display("FAIL midrst_enable_cpu cyc %0d got %b exp 0", c, enable_cpu); end
      checks++; if (smallfifo_rd_en !== 1'b0) begin errors++; $display("FAIL midrst_idle_rd_en cyc %0d got %b exp 0", c, smallfifo_rd_en); end
      step();
    end
  endtask

  // Packet-level model: phase 0 waiting, 1 transferring, 2 handoff.
  // The bench plays the arbiter: a handed-off thread is owned until released,
  // raising busy 1-2 cycles after enable_cpu and holding it a random time.
  task automatic test_random();
    logic [NT-1:0] owned;
    logic [NT-1:0] free;
    int echo[NT];
    int hold[NT];
    int phase, last, exp_thr, len, done, m_count, npkt;
    do_reset();
    owned = '0;
    for (int i = 0; i < NT; i++) begin echo[i] = 0; hold[i] = 0; end
    phase = 0; last = NT - 1; exp_thr = 0; len = 0; done = 0; m_count = 0; npkt = 0;
    for (int cyc = 0; cyc < 4000 && npkt < 60; cyc++) begin
      for (int i = 0; i < NT; i++) begin
        if (owned[i]) begin
          if (echo[i] > 0) echo[i]--;
          else if (hold[i] > 0) hold[i]--;
          else owned[i] = 1'b0;
        end
      end
      if (phase == 2) begin
        owned[exp_thr] = 1'b1;
        echo[exp_thr]  = int'($urandom_range(1, 2));
        hold[exp_thr]  = int'($urandom_range(0, 6));
      end
      for (int i = 0; i < NT; i++) fifo_busy[i] = owned[i] && (echo[i] == 0);

      checks++; if (smallfifo_rd_en !== (phase == 1)) begin errors++; $display("FAIL rnd_rd_en cyc %0d got %b exp %b", cyc, smallfifo_rd_en, phase == 1); end
      checks++; if (enable_cpu !== (phase == 2)) begin errors++; $display("FAIL rnd_enable_cpu cyc %0d got %b exp %b", cyc, enable_cpu, phase == 2); end
      checks++; if (pkt_count !== CB'(m_count)) begin errors++; $display("FAIL rnd_pkt_count cyc %0d got %0d exp %0d", cyc, pkt_count, m_count); end
      if (phase == 1) begin
        checks++; if (thread_sel !== TB'(exp_thr)) begin errors++; $display("FAIL rnd_thread_sel cyc %0d got %0d exp %0d", cyc, thread_sel, exp_thr); end
      end

      idle_inputs();
      free = ~owned;
      if (phase == 0) begin
        pkt_avail = ($urandom_range(0, 3) != 0);
        #1;
        checks++; if (sched_valid !== (free != '0)) begin errors++; $display("FAIL rnd_sched_valid cyc %0d got %b exp %b", cyc, sched_valid, free != '0); end
        checks++; if (thread_sel_next !== TB'(rr_model(last, free))) begin errors++; $display("FAIL rnd_thread_sel_next cyc %0d got %0d exp %0d", cyc, thread_sel_next, rr_model(last, free)); end
      end else if (phase == 1 && $urandom_range(0, 2) != 0) begin
        word(done == 0, done == len - 1);
      end

      case (phase)
        0: if (pkt_avail && free != '0) begin
          exp_thr = rr_model(last, free);
          last    = exp_thr;
          phase   = 1;
          done    = 0;
          len     = int'($urandom_range(1, 5));
        end
        1: if (word_valid) begin
          done++;
          if (done == len) phase = 2;
        end
        default: begin
          phase = 0;
          m_count++;
          npkt++;
        end
      endcase
      step();
    end
    checks++; if (npkt != 60) begin errors++; $display("FAIL rnd_timeout packets got %0d exp 60", npkt); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rnd_proto_err got %b exp 0", proto_err); end
    idle_inputs();
    fifo_busy = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    fifo_busy = '0;
    reset     = 1'b1;
    test_reset();
    test_single_packet();
    test_back_to_back();
    test_all_busy();
    test_skip_busy();
    test_proto_err();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
